// File: rtl/lp805x_sfrfifo.sv
// lp805x_sfrfifo: SFR-bus slave with a byte FIFO behind STAT (bit-addressable),
// DATA (write pushes, read pops) and CNT (occupancy), plus a level interrupt.
// Optional watermark SFR at CNT_ADDR+1 is enabled by defining
// LP805X_SFRFIFO_WATERMARK_EN.
module lp805x_sfrfifo #(
  parameter logic [7:0]  STAT_ADDR  = 8'hD8,
  parameter logic [7:0]  DATA_ADDR  = 8'hD9,
  parameter logic [7:0]  CNT_ADDR   = 8'hDA,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [28:0] sfr_bus_in,
  output logic [8:0]  sfr_bus_out,
  output logic        sfr_sel,
  output logic        irq
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Request bus fields
  logic [7:0] wr_addr, rd_addr, data_in;
  logic       wr, rd, bit_in, wr_bit, rd_bit;

  assign {wr_addr, rd_addr, data_in, wr, rd, bit_in, wr_bit, rd_bit} = sfr_bus_in;

  // State
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          ovf, udf, ie, rd_hit_d;

  // Decode
  logic byte_wr, bit_wr, byte_rd, bit_rd;
  logic stat_wr, push_req, data_rd, pop_req, flush;
  logic empty, full, do_pop, do_push, ovf_set, udf_set, ovf_clr, udf_clr;
  logic ie_nxt, level, irq_cause;
  logic [7:0] stat;

  assign byte_wr  = wr & ~wr_bit;
  assign bit_wr   = wr & wr_bit & (wr_addr[7:3] == STAT_ADDR[7:3]);
  assign byte_rd  = rd & ~rd_bit;
  assign bit_rd   = rd & rd_bit & (rd_addr[7:3] == STAT_ADDR[7:3]);

  assign stat_wr  = byte_wr & (wr_addr == STAT_ADDR);
  assign push_req = byte_wr & (wr_addr == DATA_ADDR);
  assign data_rd  = byte_rd & (rd_addr == DATA_ADDR);
  // Only the first cycle of a (possibly multi-cycle) DATA read pops
  assign pop_req  = data_rd & ~rd_hit_d;

  assign flush    = (stat_wr & data_in[5]) |
                    (bit_wr & (wr_addr[2:0] == 3'd5) & bit_in);

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);

  // Pop is evaluated against the pre-push state so push+pop on empty underflows
  assign do_pop   = pop_req & ~flush & ~empty;
  assign udf_set  = pop_req & ~flush & empty;
  assign do_push  = push_req & ~flush & (~full | do_pop);
  assign ovf_set  = push_req & ~flush & full & ~do_pop;

  assign ovf_clr  = flush | (stat_wr & ~data_in[2]) |
                    (bit_wr & (wr_addr[2:0] == 3'd2) & ~bit_in);
  assign udf_clr  = flush | (stat_wr & ~data_in[3]) |
                    (bit_wr & (wr_addr[2:0] == 3'd3) & ~bit_in);

  assign ie_nxt   = stat_wr ? data_in[4] :
                    (bit_wr & (wr_addr[2:0] == 3'd4)) ? bit_in : ie;

`ifdef LP805X_SFRFIFO_WATERMARK_EN
  localparam logic [7:0] WMARK_ADDR = CNT_ADDR + 8'd1;

  logic [7:0] wmark;
  logic       wmark_wr;

  assign wmark_wr  = byte_wr & (wr_addr == WMARK_ADDR);
  assign level     = (8'(count) >= wmark) & (wmark != 8'd0);
  assign irq_cause = level | ovf | udf;

  // Watermark threshold register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           wmark <= 8'h00;
    else if (wmark_wr) wmark <= data_in;
  end
`else
  assign level     = 1'b0;
  assign irq_cause = ~empty | ovf | udf;
`endif

  assign stat = {1'b0, level, 1'b0, ie, udf, ovf, full, empty};

  // Pointers, occupancy, sticky flags, read edge detect and interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      ie       <= 1'b0;
      rd_hit_d <= 1'b0;
      irq      <= 1'b0;
    end else begin
      rd_hit_d <= data_rd;
      irq      <= ie & irq_cause;
      ie       <= ie_nxt;
      ovf      <= (ovf & ~ovf_clr) | ovf_set;
      udf      <= (udf & ~udf_clr) | udf_set;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(do_push) - CW'(do_pop);
      end
    end
  end

  // FIFO storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= data_in;
  end

  // Read response mux; zero when not selected so it can be OR-combined
  logic [7:0] data_out;
  logic       bit_out;

  always_comb begin
    data_out = 8'h00;
    bit_out  = 1'b0;
    sfr_sel  = 1'b0;
    if (byte_rd) begin
      case (rd_addr)
        STAT_ADDR: begin
          data_out = stat;
          sfr_sel  = 1'b1;
        end
        DATA_ADDR: begin
          data_out = empty ? 8'h00 : mem[rd_ptr];
          sfr_sel  = 1'b1;
        end
        CNT_ADDR: begin
          data_out = 8'(count);
          sfr_sel  = 1'b1;
        end
`ifdef LP805X_SFRFIFO_WATERMARK_EN
        WMARK_ADDR: begin
          data_out = wmark;
          sfr_sel  = 1'b1;
        end
`endif
        default: ;
      endcase
    end
    if (bit_rd) begin
      bit_out = stat[rd_addr[2:0]];
      sfr_sel = 1'b1;
    end
  end

  assign sfr_bus_out = {data_out, bit_out};

endmodule

// File: doc/lp805x_sfrfifo.md
Name: lp805x_sfrfifo

Overview:
- SFR-bus slave peripheral downstream of the registered SFR request bus.
- Decodes the 29-bit request bus and implements a byte FIFO behind three SFRs: STAT (bit-addressable), DATA and CNT.
- Returns a 9-bit {data_out, bit_out} response for the registered response-bus stage.
- Raises a level interrupt to the interrupt controller.

Parameters:
- STAT_ADDR, 8'hD8, status SFR address; low 3 bits must be 000 (bit-addressable).
- DATA_ADDR, 8'hD9, FIFO data SFR; write pushes, read pops.
- CNT_ADDR, 8'hDA, read-only occupancy SFR.
- DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 entries (range 1..7).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- sfr_bus_in  in  29  request bus: [28:21] wr_addr, [20:13] rd_addr, [12:5] data_in, [4] wr, [3] rd, [2] bit_in, [1] wr_bit, [0] rd_bit.
- sfr_bus_out  out  9  response: [8:1] data_out, [0] bit_out; all-zero when not selected, so it can be OR-combined.
- sfr_sel  out  1  combinational; rd address hits an owned byte SFR or a STAT bit.
- irq  out  1  registered interrupt request.

Behaviour:
- Access decode:
  - Byte write = wr & ~wr_bit. Bit write = wr & wr_bit, targeting STAT bit wr_addr[2:0] when wr_addr[7:3] == STAT_ADDR[7:3].
  - Byte read = rd & ~rd_bit. Bit read = rd & rd_bit, returning bit_out = STAT[rd_addr[2:0]].
- STAT layout:
  - [0] EMPTY (ro), [1] FULL (ro).
  - [2] OVF sticky, [3] UDF sticky; writing 0 clears, writing 1 has no effect.
  - [4] IE (rw).
  - [5] FLUSH: write 1 empties the FIFO and clears OVF/UDF; always reads 0.
  - [7:6] read 0.
- DATA read:
  - data_out shows the head entry combinationally while the read is active.
  - Pop occurs on the first cycle of a read hit only. A registered rd_hit_d edge-detects, so a multi-cycle rd pops once.
  - Read while empty returns 0x00 and sets UDF; pointers are unchanged.
- DATA write: push on every byte-write cycle to DATA_ADDR. Write while full discards the data and sets OVF.
- CNT: reads the occupancy, 0..2**DEPTH_LOG2, zero-extended to 8 bits. Writes are ignored.
- Simultaneous events:
  - Push+pop when full: both succeed, count unchanged, no OVF.
  - Push+pop when empty: pop returns 0x00 and sets UDF; push succeeds; count becomes 1.
  - FLUSH in the same cycle as push or pop: flush wins, the push is discarded, no OVF/UDF set.
  - A bit write and a byte write to STAT in the same cycle cannot occur (single bus); if both decode, the byte write wins.
- Pointer arithmetic: rd_ptr and wr_ptr are DEPTH_LOG2 bits and wrap modulo depth. Count is a separate DEPTH_LOG2+1-bit register.
- irq: registered each cycle as IE & (~EMPTY | OVF | UDF); one-cycle latency after the cause.
- Reset (async):
  - Pointers and count 0; STAT = 8'h01; IE, OVF, UDF 0; irq 0; rd_hit_d 0.
  - FIFO storage is not reset.
  - Reset asserted mid-access abandons the access; no push or pop completes.
- Unowned addresses: sfr_bus_out = 0, sfr_sel = 0, no state change.

Optional Feature:
- Macro: LP805X_SFRFIFO_WATERMARK_EN.
- With the macro:
  - Adds the WMARK rw SFR at CNT_ADDR+1, reset 8'h00.
  - STAT[6] LEVEL = (count >= WMARK) & (WMARK != 0).
  - irq = IE & (LEVEL | OVF | UDF); ~EMPTY no longer contributes.
- Without the macro:
  - CNT_ADDR+1 is unowned (reads 0, sfr_sel 0).
  - STAT[6] reads 0.
  - irq as defined above.

Test Plan:
- Reset, then byte-read STAT -> 8'h01, CNT -> 0, irq 0, sfr_bus_out 0 on an idle bus.
- Push 0x11,0x22,...,0x88 (8 writes, depth 8) -> FULL=1, CNT=8. Ninth push 0x99 -> OVF=1, CNT=8. Eight pops return 0x11..0x88 in order; then EMPTY=1.
- Pop when empty -> data_out 0x00, UDF=1. Bit-write STAT.3=0 -> UDF=0. Bit-read STAT.0 -> bit_out 1.
- Hold rd on DATA for 3 cycles with 2 entries -> exactly one pop, CNT 2->1.
- With the FIFO full, push+pop in the same cycle -> head returned, CNT stays 8, OVF stays 0. Wrap-around verified over 20 push/pop cycles with matching data.
- Set IE, push one byte -> irq=1 one cycle later. Write STAT 8'h30 (FLUSH+IE) -> CNT=0, irq falls the following cycle.
- (with LP805X_SFRFIFO_WATERMARK_EN) WMARK=3: pushes 1,2 -> irq 0; push 3 -> LEVEL=1, irq 1.
